// File: rtl/burst_ram_arbiter_pkg.sv
// Shared types and constants for the two-master BurstRAM arbiter.
// Beat counter width is sized so a full read burst (COUNT) is representable.
package burst_ram_arbiter_pkg;

  localparam int RAM_DEPTH_BITWIDTH      = 4;
  localparam int RAM_BURST_DATA_BITWIDTH = 64;
  localparam int RAM_BURST_DATA_COUNT    = 4;
  localparam int RAM_MASK_BITWIDTH       = RAM_BURST_DATA_BITWIDTH / 8;
  localparam int BEAT_W                  = $clog2(RAM_BURST_DATA_COUNT + 1);

  typedef logic [RAM_DEPTH_BITWIDTH-1:0]      addr_t;
  typedef logic [RAM_BURST_DATA_BITWIDTH-1:0] data_t;
  typedef logic [RAM_MASK_BITWIDTH-1:0]       mask_t;
  typedef logic [BEAT_W-1:0]                  beat_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  localparam logic BR_CMD_READ  = 1'b0;
  localparam logic BR_CMD_WRITE = 1'b1;

  localparam beat_t BEATS_RD = beat_t'(RAM_BURST_DATA_COUNT);
  localparam beat_t BEATS_WR = beat_t'(RAM_BURST_DATA_COUNT - 1);

  function automatic port_t other_port(input port_t p);
    return (p == PORT_I) ? PORT_D : PORT_I;
  endfunction

endpackage

// File: rtl/burst_ram_arbiter_if.sv
// Cache-side burst port: req/gnt ownership handshake, command/write lanes and read return.
// master = cache, slave = arbiter.
interface burst_ram_arbiter_if;
  import burst_ram_arbiter_pkg::*;

  logic  req;
  logic  gnt;
  logic  cmd;
  logic  cmd_en;
  addr_t addr;
  data_t wr_data;
  mask_t data_mask;
  data_t rd_data;
  logic  rd_data_valid;
  logic  busy;

  modport master (
    output req, cmd, cmd_en, addr, wr_data, data_mask,
    input  gnt, rd_data, rd_data_valid, busy
  );

  modport slave (
    input  req, cmd, cmd_en, addr, wr_data, data_mask,
    output gnt, rd_data, rd_data_valid, busy
  );

endinterface

// File: rtl/burst_ram_arbiter_beat_counter.sv
// Outstanding-beat tracker: loads on a forwarded command, counts read valids or write cycles.
// zero_o is high when no beats of the current burst remain.
module burst_ram_arbiter_beat_counter
  import burst_ram_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic load_wr_i,
  input  logic rd_valid_i,
  output logic zero_o
);

  beat_t beats_q, beats_d;
  logic  wr_mode_q, wr_mode_d;

  // Write beat 0 rides with the command, so writes drain one per cycle from COUNT-1.
  always_comb begin
    beats_d   = beats_q;
    wr_mode_d = wr_mode_q;
    if (load_i) begin
      wr_mode_d = load_wr_i;
      beats_d   = load_wr_i ? BEATS_WR : BEATS_RD;
    end else if ((beats_q != '0) && (wr_mode_q || rd_valid_i)) begin
      beats_d = beats_q - beat_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beats_q   <= '0;
      wr_mode_q <= 1'b0;
    end else begin
      beats_q   <= beats_d;
      wr_mode_q <= wr_mode_d;
    end
  end

  assign zero_o = (beats_q == '0);

endmodule

// File: rtl/burst_ram_arbiter.sv
// Round-robin owner of the single BurstRAM port shared by the I and D cache fill masters.
// Grant is held until the owner drops req and its burst has fully drained.
module burst_ram_arbiter
  import burst_ram_arbiter_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  burst_ram_arbiter_if.slave        i_port,
  burst_ram_arbiter_if.slave        d_port,
  output logic                      br_cmd_o,
  output logic                      br_cmd_en_o,
  output addr_t                     br_addr_o,
  output data_t                     br_wr_data_o,
  output mask_t                     br_data_mask_o,
  input  data_t                     br_rd_data_i,
  input  logic                      br_rd_data_valid_i,
  input  logic                      br_busy_i,
  output logic                      protocol_err_o
);

  state_t state_q;
  port_t  owner_q;
  port_t  rr_ptr_q;
  logic   gnt_i_q;
  logic   gnt_d_q;
  logic   protocol_err_q, protocol_err_d;

  logic   any_gnt;
  logic   sel_d;
  logic   own_req;
  logic   other_req;
  logic   own_cmd;
  logic   own_cmd_en;
  addr_t  own_addr;
  data_t  own_wr_data;
  mask_t  own_mask;
  logic   beats_zero;
  logic   fwd;
  logic   release_own;
  logic   err_set;

  assign any_gnt   = gnt_i_q | gnt_d_q;
  assign sel_d     = (owner_q == PORT_D);
  assign own_req   = sel_d ? d_port.req : i_port.req;
  assign other_req = sel_d ? i_port.req : d_port.req;

  always_comb begin
    own_cmd     = 1'b0;
    own_cmd_en  = 1'b0;
    own_addr    = '0;
    own_wr_data = '0;
    own_mask    = '0;
    if (any_gnt) begin
      if (sel_d) begin
        own_cmd     = d_port.cmd;
        own_cmd_en  = d_port.cmd_en;
        own_addr    = d_port.addr;
        own_wr_data = d_port.wr_data;
        own_mask    = d_port.data_mask;
      end else begin
        own_cmd     = i_port.cmd;
        own_cmd_en  = i_port.cmd_en;
        own_addr    = i_port.addr;
        own_wr_data = i_port.wr_data;
        own_mask    = i_port.data_mask;
      end
    end
  end

  assign fwd         = own_cmd_en & beats_zero & ~br_busy_i;
  assign release_own = any_gnt & ~own_req & beats_zero & ~fwd;

  burst_ram_arbiter_beat_counter u_beats (
    .clk        (clk),
    .rst        (rst),
    .load_i     (fwd),
    .load_wr_i  (own_cmd == BR_CMD_WRITE),
    .rd_valid_i (br_rd_data_valid_i),
    .zero_o     (beats_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= PORT_I;
      rr_ptr_q <= PORT_I;
      gnt_i_q  <= 1'b0;
      gnt_d_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_port.req || d_port.req) begin
            state_q <= ST_OWNED;
            if (i_port.req && (!d_port.req || rr_ptr_q == PORT_I)) begin
              owner_q <= PORT_I;
              gnt_i_q <= 1'b1;
            end else begin
              owner_q <= PORT_D;
              gnt_d_q <= 1'b1;
            end
          end
        end
        ST_OWNED: begin
          if (release_own) begin
            rr_ptr_q <= other_port(owner_q);
            if (other_req) begin
              owner_q <= other_port(owner_q);
              gnt_i_q <= sel_d;
              gnt_d_q <= ~sel_d;
            end else begin
              state_q <= ST_IDLE;
              gnt_i_q <= 1'b0;
              gnt_d_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_i_q <= 1'b0;
          gnt_d_q <= 1'b0;
        end
      endcase
    end
  end

  // Dropped owner strobes, any non-owner strobe, and read returns with nothing outstanding.
  assign err_set = (own_cmd_en & ~fwd)
                 | (i_port.cmd_en & ~gnt_i_q)
                 | (d_port.cmd_en & ~gnt_d_q)
                 | (br_rd_data_valid_i & beats_zero);

  assign protocol_err_d = protocol_err_q | err_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      protocol_err_q <= 1'b0;
    end else begin
      protocol_err_q <= protocol_err_d;
    end
  end

  assign br_cmd_o       = own_cmd;
  assign br_cmd_en_o    = fwd;
  assign br_addr_o      = own_addr;
  assign br_wr_data_o   = own_wr_data;
  assign br_data_mask_o = own_mask;
  assign protocol_err_o = protocol_err_q;

  assign i_port.gnt           = gnt_i_q;
  assign i_port.rd_data       = br_rd_data_i;
  assign i_port.rd_data_valid = gnt_i_q & br_rd_data_valid_i;
  assign i_port.busy          = gnt_i_q ? (br_busy_i | ~beats_zero) : 1'b1;

  assign d_port.gnt           = gnt_d_q;
  assign d_port.rd_data       = br_rd_data_i;
  assign d_port.rd_data_valid = gnt_d_q & br_rd_data_valid_i;
  assign d_port.busy          = gnt_d_q ? (br_busy_i | ~beats_zero) : 1'b1;

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed bench for burst_ram_arbiter; read returns and write beats are scoreboarded.
module tb_burst_ram_arbiter;

  typedef struct packed {
    logic [1:0]  port;
    logic [63:0] data;
  } rd_exp_t;

  logic        clk;
  logic        rst;
  logic        br_cmd;
  logic        br_cmd_en;
  logic [3:0]  br_addr;
  logic [63:0] br_wr_data;
  logic [7:0]  br_data_mask;
  logic [63:0] br_rd_data;
  logic        br_rd_data_valid;
  logic        br_busy;
  logic        protocol_err;

  int n_cmp;
  int n_err;

  rd_exp_t     sb[$];
  logic [63:0] wq[$];
  rd_exp_t     mon_e;
  logic [63:0] wexp;

  burst_ram_arbiter_if ip ();
  burst_ram_arbiter_if dp ();

  burst_ram_arbiter dut (
    .clk                (clk),
    .rst                (rst),
    .i_port             (ip),
    .d_port             (dp),
    .br_cmd_o           (br_cmd),
    .br_cmd_en_o        (br_cmd_en),
    .br_addr_o          (br_addr),
    .br_wr_data_o       (br_wr_data),
    .br_data_mask_o     (br_data_mask),
    .br_rd_data_i       (br_rd_data),
    .br_rd_data_valid_i (br_rd_data_valid),
    .br_busy_i          (br_busy),
    .protocol_err_o     (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    ip.req = 1'b0; ip.cmd = 1'b0; ip.cmd_en = 1'b0; ip.addr = '0; ip.wr_data = '0; ip.data_mask = '0;
    dp.req = 1'b0; dp.cmd = 1'b0; dp.cmd_en = 1'b0; dp.addr = '0; dp.wr_data = '0; dp.data_mask = '0;
    br_rd_data = '0; br_rd_data_valid = 1'b0; br_busy = 1'b0;
  endtask

  // Called just after a rising edge; one read beat per cycle.
  task automatic rd_burst(input bit to_d, input logic [63:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      sb.push_back('{port: (to_d ? 2'b10 : 2'b01), data: base + 64'(k)});
      br_rd_data       = base + 64'(k);
      br_rd_data_valid = 1'b1;
      smp();
      step();
    end
    br_rd_data_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && (ip.rd_data_valid || dp.rd_data_valid)) begin
      if (sb.size() == 0) begin
        chk("rd_unexpected", 64'({dp.rd_data_valid, ip.rd_data_valid}), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rd_port", 64'({dp.rd_data_valid, ip.rd_data_valid}), 64'(mon_e.port));
        chk("rd_data", ip.rd_data_valid ? ip.rd_data : dp.rd_data, mon_e.data);
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    clear_inputs();

    smp();
    chk("rst_i_gnt", 64'(ip.gnt), 64'd0);
    chk("rst_d_gnt", 64'(dp.gnt), 64'd0);
    chk("rst_br_cmd_en", 64'(br_cmd_en), 64'd0);
    chk("rst_br_addr", 64'(br_addr), 64'd0);
    chk("rst_perr", 64'(protocol_err), 64'd0);
    chk("rst_i_busy", 64'(ip.busy), 64'd1);
    step();
    rst = 1'b0;

    // I alone: read burst to address 3
    ip.req = 1'b1;
    smp();
    chk("t1_gnt_before_edge", 64'(ip.gnt), 64'd0);
    step();
    smp();
    chk("t1_i_gnt", 64'(ip.gnt), 64'd1);
    chk("t1_d_gnt", 64'(dp.gnt), 64'd0);
    step();
    ip.cmd = 1'b0; ip.cmd_en = 1'b1; ip.addr = 4'd3;
    smp();
    chk("t1_br_cmd_en", 64'(br_cmd_en), 64'd1);
    chk("t1_br_addr", 64'(br_addr), 64'd3);
    chk("t1_br_cmd", 64'(br_cmd), 64'd0);
    step();
    ip.cmd_en = 1'b0;
    smp();
    chk("t1_i_busy_outstanding", 64'(ip.busy), 64'd1);
    step();
    rd_burst(1'b0, 64'hA0, 4);
    chk("t1_rd_drain", 64'(sb.size()), 64'd0);
    ip.req = 1'b0;
    smp();
    chk("t1_gnt_held", 64'(ip.gnt), 64'd1);
    chk("t1_i_busy_drained", 64'(ip.busy), 64'd0);
    step();
    smp();
    chk("t1_i_gnt_fall", 64'(ip.gnt), 64'd0);

    // rr pointer now at D: simultaneous request goes to D, then hands back to I
    ip.req = 1'b1; dp.req = 1'b1;
    step();
    smp();
    chk("t1b_rr_d_gnt", 64'(dp.gnt), 64'd1);
    chk("t1b_rr_i_gnt", 64'(ip.gnt), 64'd0);
    dp.req = 1'b0;
    step();
    smp();
    chk("t1b_hand_d_gnt", 64'(dp.gnt), 64'd0);
    chk("t1b_hand_i_gnt", 64'(ip.gnt), 64'd1);
    ip.req = 1'b0;
    step();
    smp();
    chk("t1b_idle_i_gnt", 64'(ip.gnt), 64'd0);

    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;

    // Both request after reset: I first, then same-edge handover to D, then back to I
    ip.req = 1'b1; dp.req = 1'b1;
    step();
    smp();
    chk("t2_first_i_gnt", 64'(ip.gnt), 64'd1);
    chk("t2_first_d_gnt", 64'(dp.gnt), 64'd0);
    ip.req = 1'b0;
    step();
    smp();
    chk("t2_hand_i_gnt", 64'(ip.gnt), 64'd0);
    chk("t2_hand_d_gnt", 64'(dp.gnt), 64'd1);
    ip.req = 1'b1; dp.req = 1'b0;
    step();
    smp();
    chk("t2_back_i_gnt", 64'(ip.gnt), 64'd1);
    chk("t2_back_d_gnt", 64'(dp.gnt), 64'd0);
    ip.req = 1'b0;
    step();

    // D write burst, four beats on consecutive cycles
    dp.req = 1'b1;
    step();
    for (int k = 0; k < 4; k++) wq.push_back(64'((k + 1) * 17));
    for (int k = 0; k < 4; k++) begin
      dp.cmd       = 1'b1;
      dp.cmd_en    = (k == 0);
      dp.addr      = 4'd5;
      dp.data_mask = 8'hFF;
      dp.wr_data   = 64'((k + 1) * 17);
      smp();
      wexp = wq.pop_front();
      chk("t3_br_wr_data", br_wr_data, wexp);
      chk("t3_br_mask", 64'(br_data_mask), 64'hFF);
      if (k == 0) begin
        chk("t3_br_cmd_en", 64'(br_cmd_en), 64'd1);
        chk("t3_br_cmd", 64'(br_cmd), 64'd1);
        chk("t3_br_addr", 64'(br_addr), 64'd5);
      end else begin
        chk("t3_d_busy_beat", 64'(dp.busy), 64'd1);
        chk("t3_no_cmd_en", 64'(br_cmd_en), 64'd0);
      end
      step();
    end
    dp.cmd_en = 1'b0;
    smp();
    chk("t3_d_busy_done", 64'(dp.busy), 64'd0);
    dp.req = 1'b0;
    dp.wr_data = '0;
    step();

    // Non-owner strobe while I owns
    ip.req = 1'b1;
    step();
    smp();
    chk("t4_i_gnt", 64'(ip.gnt), 64'd1);
    chk("t4_perr_clean", 64'(protocol_err), 64'd0);
    step();
    dp.cmd_en = 1'b1; dp.cmd = 1'b0;
    smp();
    chk("t4_br_cmd_en_blocked", 64'(br_cmd_en), 64'd0);
    step();
    dp.cmd_en = 1'b0;
    smp();
    chk("t4_perr_set", 64'(protocol_err), 64'd1);
    step();
    step();
    smp();
    chk("t4_perr_sticky", 64'(protocol_err), 64'd1);

    // I drops req after two of four read beats; D waiting
    dp.req = 1'b1;
    step();
    ip.cmd = 1'b0; ip.cmd_en = 1'b1; ip.addr = 4'd7;
    smp();
    chk("t5_br_cmd_en", 64'(br_cmd_en), 64'd1);
    chk("t5_br_addr", 64'(br_addr), 64'd7);
    step();
    ip.cmd_en = 1'b0;
    rd_burst(1'b0, 64'hB0, 2);
    ip.req = 1'b0;
    rd_burst(1'b0, 64'hB2, 2);
    chk("t5_rd_drain", 64'(sb.size()), 64'd0);
    smp();
    chk("t5_i_gnt_held", 64'(ip.gnt), 64'd1);
    chk("t5_d_gnt_wait", 64'(dp.gnt), 64'd0);
    step();
    smp();
    chk("t5_i_gnt_rel", 64'(ip.gnt), 64'd0);
    chk("t5_d_gnt_new", 64'(dp.gnt), 64'd1);

    // Reset in the middle of a D read burst, between clock edges
    step();
    dp.cmd = 1'b0; dp.cmd_en = 1'b1; dp.addr = 4'd2;
    smp();
    chk("t6_br_cmd_en", 64'(br_cmd_en), 64'd1);
    step();
    dp.cmd_en = 1'b0;
    rd_burst(1'b1, 64'hC0, 2);
    chk("t6_pre_br_addr", 64'(br_addr), 64'd2);
    chk("t6_pre_perr", 64'(protocol_err), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_d_gnt", 64'(dp.gnt), 64'd0);
    chk("t6_rst_i_gnt", 64'(ip.gnt), 64'd0);
    chk("t6_rst_br_cmd_en", 64'(br_cmd_en), 64'd0);
    chk("t6_rst_br_addr", 64'(br_addr), 64'd0);
    chk("t6_rst_perr", 64'(protocol_err), 64'd0);
    chk("t6_rst_d_busy", 64'(dp.busy), 64'd1);
    clear_inputs();
    step();
    step();
    rst = 1'b0;
    ip.req = 1'b1;
    step();
    smp();
    chk("t6_fresh_i_gnt", 64'(ip.gnt), 64'd1);

    // Owner strobe while BurstRAM is busy is dropped and flagged
    step();
    br_busy = 1'b1;
    ip.cmd = 1'b0; ip.cmd_en = 1'b1;
    smp();
    chk("t7_busy_blocks_cmd", 64'(br_cmd_en), 64'd0);
    chk("t7_i_busy", 64'(ip.busy), 64'd1);
    step();
    ip.cmd_en = 1'b0;
    br_busy = 1'b0;
    smp();
    chk("t7_perr", 64'(protocol_err), 64'd1);
    chk("end_rd_drain", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
